// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream input and instruction-memory write port of the boot loader
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length/payload/checksum byte image into instruction memory
// and holds the core in reset until the image is complete and verified.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_boot_loader_if.slave     bus,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [31:0]           sum_q, sum_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [31:0]           full_word;

  // Lower three lanes are held in asm_q; the fourth byte completes the word combinationally.
  assign accept    = bus.in_valid && in_ready_q;
  assign full_word = {bus.in_data, asm_q};

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    n_d          = n_q;
    sum_d        = sum_q;
    words_d      = words_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    asm_d[7:0]   = bus.in_data;
        2'd1:    asm_d[15:8]  = bus.in_data;
        2'd2:    asm_d[23:16] = bus.in_data;
        default: asm_d        = asm_q;
      endcase

      if (byte_idx_q == 2'd3) begin
        case (state_q)
          S_HDR: begin
            if (full_word > 32'(MAX_WORDS)) begin
              state_d = S_ERROR;
            end else if (full_word == 32'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_LOAD;
              n_d     = full_word[ADDR_WIDTH:0];
            end
          end
          S_LOAD: begin
            // Write, count and checksum all land on the same edge so imem_addr shows the old count.
            imem_we_d    = 1'b1;
            imem_addr_d  = words_q[ADDR_WIDTH-1:0];
            imem_wdata_d = full_word;
            words_d      = words_q + CNT_ONE;
            sum_d        = sum_q + full_word;
            if (words_q + CNT_ONE == n_q) begin
              state_d = S_CSUM;
            end
          end
          S_CSUM: begin
            state_d = (full_word == sum_q) ? S_DONE : S_ERROR;
          end
          default: state_d = state_q;
        endcase
      end
    end

    in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CSUM);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
    core_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      byte_idx_q   <= 2'd0;
      asm_q        <= 24'd0;
      n_q          <= '0;
      sum_q        <= 32'd0;
      words_q      <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      n_q          <= n_d;
      sum_q        <= sum_d;
      words_q      <= words_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized image streams checked against an image-level reference model
module tb_imem_boot_loader;
  localparam int AW   = 10;
  localparam int MAXW = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_rst;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] img_words[$];
  logic [7:0]  bq[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          cyc          = 0;
  int          last_we_cyc  = -1;
  int          rst_fall_cyc = -1;
  int          we_wide      = 0;
  logic        prev_we      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_we) begin
        wr_addr_q.push_back(32'(bus.imem_addr));
        wr_data_q.push_back(bus.imem_wdata);
        if (prev_we) we_wide++;
        last_we_cyc = cyc;
      end
      if (!core_rst && rst_fall_cyc < 0) rst_fall_cyc = cyc;
    end
    prev_we = bus.imem_we;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);
    wr_addr_q.delete();
    wr_data_q.delete();
    last_we_cyc  = -1;
    rst_fall_cyc = -1;
    we_wide      = 0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);
  endtask

  // Presents bq[0..count-1]; returns right after the edge that accepts the last byte.
  task automatic send_bytes(input int count, input int gap_pct);
    for (int i = 0; i < count; i++) begin
      int   gaps;
      int   waited;
      logic taken;
      gaps = 0;
      while (gaps < 8 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        gaps++;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = bq[i];
      waited = 0;
      taken  = 1'b0;
      while (!taken) begin
        logic rdy;
        rdy = bus.in_ready;
        @(posedge clk);
        if (rdy) begin
          taken = 1'b1;
        end else begin
          waited++;
          if (waited > 50) begin
            chk("byte_accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic run_image(input logic [31:0] n_field, input logic [31:0] csum,
                           input int gap_pct, input bit hdr_only);
    logic [31:0] sum;
    bit          len_ok;
    bit          exp_done;
    int          exp_cnt;
    int          n_wr;
    logic [AW:0] wl_end;
    do_reset();
    bq.delete();
    push_word(n_field);
    if (!hdr_only) begin
      foreach (img_words[i]) push_word(img_words[i]);
      push_word(csum);
    end
    send_bytes(bq.size(), gap_pct);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;

    sum = 32'd0;
    foreach (img_words[i]) sum = sum + img_words[i];
    len_ok   = (n_field <= 32'(MAXW));
    exp_done = len_ok && (csum == sum);
    exp_cnt  = len_ok ? img_words.size() : 0;

    chk("done", done, 64'(exp_done));
    chk("error", error, 64'(!exp_done));
    chk("core_rst", core_rst, 64'(!exp_done));
    chk("in_ready_terminal", bus.in_ready, 0);
    chk("words_loaded", words_loaded, 64'(exp_cnt));
    chk("write_count", wr_data_q.size(), 64'(exp_cnt));
    for (int i = 0; i < exp_cnt && i < wr_data_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 64'(i));
      chk($sformatf("wr_data[%0d]", i), wr_data_q[i], img_words[i]);
    end
    chk("we_single_cycle", we_wide, 0);
    if (exp_done && exp_cnt > 0)
      chk("last_write_before_core_rst", 64'(rst_fall_cyc - last_we_cyc >= 4), 1);

    n_wr   = wr_data_q.size();
    wl_end = words_loaded;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("ignored_no_write", wr_data_q.size(), 64'(n_wr));
    chk("ignored_words_loaded", words_loaded, 64'(wl_end));
    chk("ignored_done_sticky", done, 64'(exp_done));
    chk("ignored_error_sticky", error, 64'(!exp_done));
  endtask

  function automatic void load_image1();
    img_words.delete();
    img_words.push_back(32'h00500093);
    img_words.push_back(32'h00A00113);
  endfunction

  initial begin
    logic [31:0] s;
    int          n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    load_image1();
    run_image(32'd2, 32'h00F001A6, 0, 0);
    run_image(32'd2, 32'h00F001A7, 0, 0);

    img_words.delete();
    run_image(32'd0, 32'h00000000, 0, 0);
    run_image(32'd0, 32'h00000001, 0, 0);
    run_image(32'h00000401, 32'd0, 0, 1);

    img_words.delete();
    s = 32'd0;
    for (int i = 0; i < MAXW; i++) begin
      img_words.push_back($urandom);
      s = s + img_words[i];
    end
    run_image(32'(MAXW), s, 0, 0);

    load_image1();
    for (int r = 0; r < 3; r++) run_image(32'd2, 32'h00F001A6, 40, 0);

    do_reset();
    bq.delete();
    push_word(32'd2);
    foreach (img_words[i]) push_word(img_words[i]);
    push_word(32'h00F001A6);
    send_bytes(9, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("midload_words_loaded", words_loaded, 1);
    chk("midload_write_count", wr_data_q.size(), 1);
    chk("midload_core_rst", core_rst, 1);
    run_image(32'd2, 32'h00F001A6, 0, 0);

    for (int r = 0; r < 10; r++) begin
      img_words.delete();
      if ($urandom_range(9) == 0) begin
        run_image(32'(MAXW + 1) + 32'($urandom_range(1 << 20)), 32'd0, 20, 1);
      end else begin
        n = $urandom_range(8, 1);
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
          img_words.push_back($urandom);
          s = s + img_words[i];
        end
        if ($urandom_range(1) == 1) s = s ^ (32'd1 << $urandom_range(31));
        run_image(32'(n), s, $urandom_range(50), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
